// File: rtl/alu_operand_loader_if.sv
// Byte-in / operand-out bundle between the serial receiver, the loader and the ALU.
interface alu_operand_loader_if #(
  parameter int unsigned N_BITS = 6
);
  logic [7:0]        i_data;
  logic              i_valid;
  logic              i_ack;
  logic [N_BITS-1:0] o_a;
  logic [N_BITS-1:0] o_b;
  logic [N_BITS-1:0] o_op;
  logic              o_valid;
  logic              o_err;
  logic [1:0]        o_err_code;
  logic              o_busy;

  modport master (
    output i_data, i_valid, i_ack,
    input  o_a, o_b, o_op, o_valid, o_err, o_err_code, o_busy
  );

  modport slave (
    input  i_data, i_valid, i_ack,
    output o_a, o_b, o_op, o_valid, o_err, o_err_code, o_busy
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Collects A, B, OP bytes into one operand set for the ALU, held until acknowledged.
// Rejects illegal opcodes, aborts stalled frames and flags bytes dropped while holding.
module alu_operand_loader #(
  parameter int unsigned N_BITS  = 6,
  parameter int unsigned TIMEOUT = 1000
) (
  input logic                 clock,
  input logic                 reset,
  alu_operand_loader_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ErrOpcode  = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;
  localparam logic [1:0] ErrOverrun = 2'b11;

  typedef enum logic [1:0] {StWaitA, StWaitB, StWaitOp, StHold} state_e;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] shadow_a_q, shadow_a_d;
  logic [N_BITS-1:0] shadow_b_q, shadow_b_d;
  logic [CntW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic [N_BITS-1:0] op_q, op_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;

  logic [N_BITS-1:0] in_byte;
  logic              op_legal;
  logic              idle_expired;
  logic              unused_data;

  assign in_byte     = bus.i_data[N_BITS-1:0];
  assign unused_data = ^bus.i_data;

  // Opcodes are defined as 6-bit codes; narrower or wider operands use their low N_BITS.
  assign op_legal = in_byte inside {N_BITS'(6'b100000), N_BITS'(6'b100010),
                                    N_BITS'(6'b100100), N_BITS'(6'b100101),
                                    N_BITS'(6'b100110), N_BITS'(6'b100111),
                                    N_BITS'(6'b000011), N_BITS'(6'b000010)};

  assign idle_expired = (idle_cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    idle_cnt_d = '0;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    unique case (state_q)
      StWaitA: begin
        if (bus.i_valid) begin
          shadow_a_d = in_byte;
          state_d    = StWaitB;
        end
      end

      StWaitB: begin
        if (bus.i_valid) begin
          shadow_b_d = in_byte;
          state_d    = StWaitOp;
        end else if (idle_expired) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
          shadow_a_d = '0;
          shadow_b_d = '0;
          state_d    = StWaitA;
        end else begin
          idle_cnt_d = idle_cnt_q + CntW'(1);
        end
      end

      StWaitOp: begin
        if (bus.i_valid) begin
          if (op_legal) begin
            a_d     = shadow_a_q;
            b_d     = shadow_b_q;
            op_d    = in_byte;
            valid_d = 1'b1;
            state_d = StHold;
          end else begin
            err_d      = 1'b1;
            err_code_d = ErrOpcode;
            state_d    = StWaitA;
          end
        end else if (idle_expired) begin
          err_d      = 1'b1;
          err_code_d = ErrTimeout;
          shadow_a_d = '0;
          shadow_b_d = '0;
          state_d    = StWaitA;
        end else begin
          idle_cnt_d = idle_cnt_q + CntW'(1);
        end
      end

      StHold: begin
        if (bus.i_ack) begin
          valid_d = 1'b0;
          // A byte arriving with the ack starts the next frame immediately.
          if (bus.i_valid) begin
            shadow_a_d = in_byte;
            state_d    = StWaitB;
          end else begin
            state_d = StWaitA;
          end
        end else if (bus.i_valid) begin
          err_d      = 1'b1;
          err_code_d = ErrOverrun;
        end
      end

      default: state_d = StWaitA;
    endcase

    busy_d = (state_d == StWaitB) || (state_d == StWaitOp);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StWaitA;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      idle_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      idle_cnt_q <= idle_cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_a        = a_q;
  assign bus.o_b        = b_q;
  assign bus.o_op       = op_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_err      = err_q;
  assign bus.o_err_code = err_code_q;
  assign bus.o_busy     = busy_q;

endmodule
